// File: rtl/hazard_pkg.sv
// Shared types and constants for the F/D/E/M/W hazard controller.
// Holds the controller state encoding and the E-stage forwarding select codes.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hazState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Register index match that never fires for x0.
  function automatic logic regHit(input logic [REG_AW_DEFAULT-1:0] src,
                                  input logic [REG_AW_DEFAULT-1:0] dst,
                                  input logic                      wrEn);
    regHit = wrEn && (src != {REG_AW_DEFAULT{1'b0}}) && (src == dst);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one E-stage source operand.
// The M-stage result is younger than W, so an M match wins over a W match.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] srcReg,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteW,
  output logic [1:0]        fwdSel
);

  logic srcNonZero;
  logic hitM;
  logic hitW;

  assign srcNonZero = (srcReg != {REG_AW{1'b0}});
  assign hitM       = srcNonZero && RegWriteM && (srcReg == WriteRegM);
  assign hitW       = srcNonZero && RegWriteW && (srcReg == WriteRegW);

  // Priority select: M, then W, then register file.
  always_comb begin
    fwdSel = FWD_RF;
    if (hitM) begin
      fwdSel = FWD_M;
    end else if (hitW) begin
      fwdSel = FWD_W;
    end else begin
      fwdSel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// enables, forwarding selects, data-memory wait and halt/resume sequencing.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcM,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hazState_t curState;
  hazState_t nextState;
  logic      loadUse;
  logic      evalRun;
  logic      haltStall;
  logic      branchFlush;
  logic      stallCntEn;
  logic      flushCntEn;

  fwd_select #(.REG_AW(REG_AW)) uFwdA (
    .srcReg    (RsE),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .fwdSel    (ForwardAE)
  );

  fwd_select #(.REG_AW(REG_AW)) uFwdB (
    .srcReg    (RtE),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .fwdSel    (ForwardBE)
  );

  assign loadUse = MemtoRegE && RegWriteE && (WriteRegE != {REG_AW{1'b0}}) &&
                   ((WriteRegE == rs1D) || (WriteRegE == rs2D));

  // Next-state and stall/flush decode.
  always_comb begin
    nextState   = curState;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    StallW      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    evalRun     = 1'b0;
    haltStall   = 1'b0;
    branchFlush = 1'b0;
    if (RST) begin
      nextState = RUN;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      FlushW    = 1'b1;
    end else begin
      case (curState)
        RUN: begin
          if (halt_req) begin
            {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
            FlushW    = 1'b1;
            haltStall = 1'b1;
            nextState = HALT;
          end else if (mem_busy) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW    = 1'b1;
            nextState = MEM_WAIT;
          end else begin
            evalRun   = 1'b1;
            nextState = RUN;
          end
        end
        MEM_WAIT: begin
          // A redirect arriving under the wait stays frozen in M until release.
          if (mem_busy) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW    = 1'b1;
            nextState = MEM_WAIT;
          end else begin
            evalRun   = 1'b1;
            nextState = RUN;
          end
        end
        HALT: begin
          {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
          haltStall = 1'b1;
          if (resume) begin
            nextState = RUN;
          end else begin
            nextState = HALT;
          end
        end
        default: begin
          nextState = RUN;
        end
      endcase

      if (evalRun && PCSrcM) begin
        {FlushD, FlushE, FlushM} = 3'b111;
        branchFlush = 1'b1;
      end else if (evalRun && loadUse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        branchFlush = branchFlush;
      end
    end
  end

  // Halt-related stalls are not performance stalls.
  assign stallCntEn = StallF && !haltStall;
  assign flushCntEn = branchFlush;

  // State register and halted flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      curState <= RUN;
      halted   <= 1'b0;
    end else begin
      curState <= nextState;
      halted   <= (nextState == HALT);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stallCntEn && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flushCntEn && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: hand-derived expectations are
// queued with each stimulus cycle and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  rs1D, rs2D, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcM;
  logic        mem_busy, halt_req, resume;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        halted;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [4:0] stall;
    logic [3:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       hlt;
  } expOut_t;

  expOut_t expQ[$];
  int      testCnt = 0;
  int      failCnt = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .rs1D(rs1D), .rs2D(rs2D), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcM(PCSrcM), .mem_busy(mem_busy),
    .halt_req(halt_req), .resume(resume),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: compare the oldest expectation mid-cycle.
  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      expOut_t e;
      e = expQ.pop_front();
      checkEq({e.tag, ".stall"}, {27'd0, StallF, StallD, StallE, StallM, StallW}, {27'd0, e.stall});
      checkEq({e.tag, ".flush"}, {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, e.flush});
      checkEq({e.tag, ".fwdA"}, {30'd0, ForwardAE}, {30'd0, e.fa});
      checkEq({e.tag, ".fwdB"}, {30'd0, ForwardBE}, {30'd0, e.fb});
      checkEq({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
    end
  end

  task automatic idleInputs();
    RST = 1'b0; rs1D = 5'd0; rs2D = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcM = 1'b0; mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Queue the expectation for the inputs currently driven, then advance one cycle.
  task automatic step(input string tag, input logic [4:0] st, input logic [3:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic hlt);
    expOut_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb; e.hlt = hlt;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idleInputs();
    RST = 1'b1;
    @(posedge CLK); #1;
    step("reset", 5'b00000, 4'b1111, 2'b00, 2'b00, 1'b0);
    checkEq("rst_stall_cnt", stall_cnt, 32'd0);
    checkEq("rst_flush_cnt", flush_cnt, 32'd0);
    RST = 1'b0;
    step("idle", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);

    // Load-use on rs1, then the load sits in M and forwards.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rs1D = 5'd5;
    step("lu_rs1", 5'b11000, 4'b0100, 2'b00, 2'b00, 1'b0);
    idleInputs(); RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1;
    step("lu_next", 5'b00000, 4'b0000, 2'b10, 2'b00, 1'b0);
    idleInputs(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; rs2D = 5'd9; rs1D = 5'd3;
    step("lu_rs2", 5'b11000, 4'b0100, 2'b00, 2'b00, 1'b0);
    idleInputs(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0;
    step("lu_x0", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);
    idleInputs(); MemtoRegE = 1'b1; RegWriteE = 1'b0; WriteRegE = 5'd4; rs1D = 5'd4;
    step("lu_nowr", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);
    checkEq("lu_stall_cnt", stall_cnt, 32'd2);

    // Branch redirect.
    idleInputs(); PCSrcM = 1'b1;
    step("branch", 5'b00000, 4'b1110, 2'b00, 2'b00, 1'b0);
    checkEq("br_flush_cnt", flush_cnt, 32'd1);
    idleInputs();
    step("br_after", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);

    // Memory wait of three cycles with a redirect pending through it.
    mem_busy = 1'b1; PCSrcM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("memwait", 5'b11110, 4'b0001, 2'b00, 2'b00, 1'b0);
    end
    checkEq("mw_stall_cnt", stall_cnt, 32'd5);
    checkEq("mw_flush_hold", flush_cnt, 32'd1);
    mem_busy = 1'b0;
    step("mw_release", 5'b00000, 4'b1110, 2'b00, 2'b00, 1'b0);
    checkEq("mw_flush_cnt", flush_cnt, 32'd2);
    idleInputs();
    step("mw_after", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);

    // Forwarding priority.
    RsE = 5'd7; RtE = 5'd7; WriteRegM = 5'd7; WriteRegW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
    step("fwd_m", 5'b00000, 4'b0000, 2'b10, 2'b10, 1'b0);
    RegWriteM = 1'b0;
    step("fwd_w", 5'b00000, 4'b0000, 2'b01, 2'b01, 1'b0);
    RsE = 5'd0;
    step("fwd_x0", 5'b00000, 4'b0000, 2'b00, 2'b01, 1'b0);
    RtE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd8;
    step("fwd_b_m", 5'b00000, 4'b0000, 2'b00, 2'b10, 1'b0);

    // Halt and resume; halt_req and mem_busy ignored while halted.
    idleInputs(); halt_req = 1'b1;
    step("halt_req", 5'b11111, 4'b0001, 2'b00, 2'b00, 1'b0);
    halt_req = 1'b0; mem_busy = 1'b1;
    step("halt1", 5'b11111, 4'b0000, 2'b00, 2'b00, 1'b1);
    mem_busy = 1'b0; halt_req = 1'b1;
    step("halt2", 5'b11111, 4'b0000, 2'b00, 2'b00, 1'b1);
    halt_req = 1'b0; resume = 1'b1;
    step("resume", 5'b11111, 4'b0000, 2'b00, 2'b00, 1'b1);
    resume = 1'b0;
    step("run_again", 5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0);
    checkEq("halt_stall_cnt", stall_cnt, 32'd5);

    // Reset in the middle of a memory wait.
    mem_busy = 1'b1;
    step("pre_rst_wait", 5'b11110, 4'b0001, 2'b00, 2'b00, 1'b0);
    RST = 1'b1;
    step("rst_in_wait", 5'b00000, 4'b1111, 2'b00, 2'b00, 1'b0);
    checkEq("rw_stall_cnt", stall_cnt, 32'd0);
    checkEq("rw_flush_cnt", flush_cnt, 32'd0);
    // Only RUN honours halt_req, which proves the wait state was left.
    idleInputs(); halt_req = 1'b1;
    step("rw_in_run", 5'b11111, 4'b0001, 2'b00, 2'b00, 1'b0);
    halt_req = 1'b0;
    step("rw_halted", 5'b11111, 4'b0000, 2'b00, 2'b00, 1'b1);

    @(negedge CLK);
    checkEq("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
